// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file port arbiter.
// No ports: provides word/index types, the arbiter state encoding and the
// default lock-burst limit.
package regfile_ctrl_pkg;

    localparam int unsigned DATA_W           = 16;
    localparam int unsigned NUM_W            = 3;
    localparam int unsigned NUM_REQ          = 2;
    localparam int unsigned LOCK_MAX_DEFAULT = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [NUM_W-1:0]  reg_num_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Lock state owned by requester idx.
    function automatic arb_state_t lock_state(input logic idx);
        return idx ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter.
// Per requester i (bit/element i): req_valid/we/num/wdata/lock in,
// req_ready grant out, rsp_valid/rsp_data read response out.
// slave = arbiter side, master = requester side.
interface regfile_port_arbiter_if;
    import regfile_ctrl_pkg::*;

    logic     [NUM_REQ-1:0] req_valid;
    logic     [NUM_REQ-1:0] req_we;
    reg_num_t [NUM_REQ-1:0] req_num;
    word_t    [NUM_REQ-1:0] req_wdata;
    logic     [NUM_REQ-1:0] req_lock;
    logic     [NUM_REQ-1:0] req_ready;
    logic     [NUM_REQ-1:0] rsp_valid;
    word_t    [NUM_REQ-1:0] rsp_data;

    modport slave (
        input  req_valid, req_we, req_num, req_wdata, req_lock,
        output req_ready, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_we, req_num, req_wdata, req_lock,
        input  req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/regfile_port_arbiter_rr.sv
// Two-way round-robin grant.
// valid      : eligible requesters
// last_grant : index of the requester granted most recently
// gnt        : one-hot (or zero) grant; on a tie the requester that did not
//              win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = valid[0] & (~valid[1] | last_grant);
        gnt[1] = valid[1] & (~valid[0] | ~last_grant);
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single write port and single read port of the 8x16 register
// file between the datapath controller (req 0) and the load/debug unit (req 1).
// clk, rst_n   : clock and synchronous active-low reset
// bus          : requester handshake, lock and read-response signals
// rf_write, rf_writenum, rf_data_in, rf_readnum : register-file drive
// rf_data_out  : register-file combinational read data
module regfile_port_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_port_arbiter_if.slave  bus,
    output logic                   rf_write,
    output reg_num_t               rf_writenum,
    output word_t                  rf_data_in,
    output reg_num_t               rf_readnum,
    input  word_t                  rf_data_out
);

    localparam int unsigned     CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    word_t [1:0]       rsp_data_q, rsp_data_d;

    logic              locked;
    logic [1:0]        elig;
    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              beat;
    logic              g;

    // Lock only restricts eligibility while the owner is still valid; an idle
    // owner releases the port in the same cycle.
    always_comb begin
        locked = 1'b0;
        elig   = bus.req_valid;
        if (state_q == LOCK0 && bus.req_valid[0]) begin
            locked = 1'b1;
            elig   = 2'b01;
        end else if (state_q == LOCK1 && bus.req_valid[1]) begin
            locked = 1'b1;
            elig   = 2'b10;
        end
    end

    rr_arbiter2 u_rr (
        .valid      (elig),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    // Nothing is granted while in reset, so the register file is never written then.
    assign gnt           = rst_n ? arb_gnt : 2'b00;
    assign beat          = |gnt;
    assign g             = gnt[1];
    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Lock FSM and round-robin history.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        if (!locked) begin
            state_d    = ARB;
            lock_cnt_d = '0;
        end
        if (beat) begin
            last_grant_d = g;
            if (locked) begin
                if (bus.req_lock[g] && lock_cnt_q < CNT_LAST) begin
                    state_d    = state_q;
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end
            end else if (bus.req_lock[g]) begin
                state_d    = lock_state(g);
                lock_cnt_d = CNT_W'(1);
            end
        end
    end

    // Read responses: capture the register file one cycle after the beat.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        if (beat && !bus.req_we[g]) begin
            rsp_valid_d[g] = 1'b1;
            rsp_data_d[g]  = rf_data_out;
        end
    end

    // Register-file port mux; buses idle at zero without a grant.
    always_comb begin
        rf_write    = 1'b0;
        rf_writenum = '0;
        rf_data_in  = '0;
        rf_readnum  = '0;
        if (beat) begin
            rf_write    = bus.req_we[g];
            rf_writenum = bus.req_num[g];
            rf_data_in  = bus.req_wdata[g];
            rf_readnum  = bus.req_num[g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule
